// File: rtl/hub75_framebuf.sv
// Double-buffered HUB75 pixel store: host writes to the back buffer, scanner reads the front one.
// Define HUB75_FB_CLEAR_EN to compile in the back-buffer clear sweep.
module hub75_framebuf #(
  parameter int COLS  = 64,
  parameter int HROWS = 16,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(HROWS)
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [CW-1:0] wr_x,
  input  logic [RW:0]   wr_y,
  input  logic [2:0]    wr_rgb,
  input  logic          swap_req,
  output logic          swap_done,
  input  logic          clear_req,
  output logic          clear_busy,
  input  logic          rd_en,
  input  logic [CW-1:0] rd_col,
  input  logic [RW-1:0] rd_row,
  input  logic          frame_end,
  output logic [2:0]    rd_rgb1,
  output logic [2:0]    rd_rgb2,
  output logic          rd_valid
);

  localparam int AW    = CW + RW;
  localparam int DEPTH = 1 << (AW + 1);

`ifdef HUB75_FB_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_SWAP_WAIT, S_CLEAR} state_t;
`else
  typedef enum logic {S_IDLE, S_SWAP_WAIT} state_t;
`endif

  state_t state_q, state_d;
  logic   front_sel_q, front_sel_d;
  logic   ready_q;
  logic   swap_done_q, swap_done_d;
  logic   rd_valid_q;
  logic [2:0] rd_rgb1_q, rd_rgb2_q;
  logic   swap_fire;
  logic   wr_fire;

  logic [2:0] top_mem [DEPTH];
  logic [2:0] bot_mem [DEPTH];

`ifdef HUB75_FB_CLEAR_EN
  logic          pending_q, pending_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_we;
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
`endif

  assign swap_fire = (state_q == S_SWAP_WAIT) && frame_end;
  assign wr_fire   = wr_valid && wr_ready;

  // State register
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      front_sel_q <= 1'b0;
      ready_q     <= 1'b0;
      swap_done_q <= 1'b0;
`ifdef HUB75_FB_CLEAR_EN
      pending_q   <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      ready_q     <= 1'b1;
      swap_done_q <= swap_done_d;
`ifdef HUB75_FB_CLEAR_EN
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q ^ swap_fire;
    swap_done_d = swap_fire;
`ifdef HUB75_FB_CLEAR_EN
    pending_d   = pending_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef HUB75_FB_CLEAR_EN
        if (clear_req) begin
          state_d   = S_CLEAR;
          pending_d = swap_req;
          cnt_d     = '0;
        end else
`endif
        if (swap_req) state_d = S_SWAP_WAIT;
      end
      S_SWAP_WAIT: begin
        if (frame_end) state_d = S_IDLE;
      end
`ifdef HUB75_FB_CLEAR_EN
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (swap_req) pending_d = 1'b1;
        if (cnt_q == AW'(HROWS * COLS - 1)) begin
          state_d   = (pending_q || swap_req) ? S_SWAP_WAIT : S_IDLE;
          pending_d = 1'b0;
          cnt_d     = '0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    wr_ready   = ready_q && (state_q == S_IDLE);
    swap_done  = swap_done_q;
`ifdef HUB75_FB_CLEAR_EN
    clear_busy = (state_q == S_CLEAR);
    clr_we     = (state_q == S_CLEAR);
`else
    clear_busy = 1'b0;
`endif
  end

  // Pixel storage is deliberately not reset
  always_ff @(posedge CLOCK_50) begin
`ifdef HUB75_FB_CLEAR_EN
    if (clr_we) begin
      top_mem[{~front_sel_q, cnt_q}] <= '0;
      bot_mem[{~front_sel_q, cnt_q}] <= '0;
    end else
`endif
    if (wr_fire) begin
      if (wr_y[RW]) bot_mem[{~front_sel_q, wr_y[RW-1:0], wr_x}] <= wr_rgb;
      else          top_mem[{~front_sel_q, wr_y[RW-1:0], wr_x}] <= wr_rgb;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_rgb1_q  <= '0;
      rd_rgb2_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_rgb1_q <= top_mem[{front_sel_q, rd_row, rd_col}];
        rd_rgb2_q <= bot_mem[{front_sel_q, rd_row, rd_col}];
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_rgb1  = rd_rgb1_q;
  assign rd_rgb2  = rd_rgb2_q;

endmodule
